ad9122_spi_slave_model: RTL and testbench

AD9122_SPI_SLAVE_MODEL -- requirements
Module: ad9122_spi_slave_model

---
 rtl/ad9122_spi_slave_model.sv | 185 ++++++++++++++++++
 tb/tb_ad9122_spi_slave_model.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ad9122_spi_slave_model.sv
// Behavioural AD9122 SPI slave: 16-bit frames, 128x8 register file,
// read-only FIFO level at 0x19, FIFO-align handshake at 0x18, soft reset via 0x00.
module ad9122_spi_slave_model #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned ALIGN_DELAY = 16,
    parameter logic [7:0]  FIFO_LEVEL  = 8'h07
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       i_reset,
    input  logic       i_sclk,
    input  logic       i_sen_n,
    input  logic       i_sda,
    output logic       o_sda,
    output logic       o_sda_dir,
    output logic       o_wr_valid,
    output logic [6:0] o_wr_addr,
    output logic [7:0] o_wr_data
);

    localparam int unsigned CNT_W      = (ALIGN_DELAY < 2) ? 1 : $clog2(ALIGN_DELAY + 1);
    localparam logic [6:0]  ADDR_SOFT  = 7'h00;
    localparam logic [6:0]  ADDR_ALIGN = 7'h18;
    localparam logic [6:0]  ADDR_FIFO  = 7'h19;

    typedef enum logic [2:0] {IDLE, INSTR, WDATA, RDATA, DONE} state_t;

    state_t state, state_next;

    logic clear;
    assign clear = !rst_n || i_reset;

    // Synchronizer stages, bit order {sda, sen_n, sclk}
    logic [2:0] sync [SYNC_STAGES];
    logic       sclk_s, sen_s, sda_s;
    logic       sclk_d, sen_d;
    logic       sclk_rise, sclk_fall, sen_fall;

    assign sclk_s    = sync[SYNC_STAGES-1][0];
    assign sen_s     = sync[SYNC_STAGES-1][1];
    assign sda_s     = sync[SYNC_STAGES-1][2];
    assign sclk_rise = sclk_s && !sclk_d;
    assign sclk_fall = !sclk_s && sclk_d;
    assign sen_fall  = !sen_s && sen_d;

    // Chip select resets to "selected" so a frame already in flight at reset
    // cannot produce a falling edge; a new frame needs sen_n high first.
    always_ff @(posedge clk_in) begin
        if (clear) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) sync[i] <= '0;
            sclk_d <= 1'b0;
            sen_d  <= 1'b0;
        end else begin
            sync[0] <= {i_sda, i_sen_n, i_sclk};
            for (int unsigned i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
            sclk_d <= sclk_s;
            sen_d  <= sen_s;
        end
    end

    logic [7:0]       regs [128];
    logic [14:0]      shift_q;
    logic [4:0]       bit_cnt;
    logic [7:0]       rd_sh;
    logic [CNT_W-1:0] align_cnt;

    logic       take_bit, rd_load, rd_shift, wr_commit;
    logic [6:0] instr_addr, wr_addr;
    logic [7:0] wr_data, rd_value;

    assign instr_addr = {shift_q[5:0], sda_s};
    assign wr_addr    = shift_q[13:7];
    assign wr_data    = {shift_q[6:0], sda_s};
    assign rd_value   = (instr_addr == ADDR_FIFO) ? FIFO_LEVEL : regs[instr_addr];

    always_ff @(posedge clk_in) begin
        if (clear) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        take_bit   = 1'b0;
        rd_load    = 1'b0;
        rd_shift   = 1'b0;
        wr_commit  = 1'b0;
        case (state)
            IDLE: if (sen_fall) state_next = INSTR;
            INSTR: begin
                if (sen_s) state_next = IDLE;
                else if (sclk_rise) begin
                    take_bit = 1'b1;
                    if (bit_cnt == 5'd7) begin
                        state_next = shift_q[6] ? RDATA : WDATA;
                        rd_load    = shift_q[6];
                    end
                end
            end
            WDATA: begin
                if (sen_s) state_next = IDLE;
                else if (sclk_rise) begin
                    take_bit = 1'b1;
                    if (bit_cnt == 5'd15) begin
                        state_next = DONE;
                        wr_commit  = 1'b1;
                    end
                end
            end
            RDATA: begin
                if (sen_s) state_next = IDLE;
                else begin
                    rd_shift = sclk_fall;
                    if (sclk_rise) begin
                        take_bit = 1'b1;
                        if (bit_cnt == 5'd15) state_next = DONE;
                    end
                end
            end
            DONE: if (sen_s) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (clear) begin
            shift_q   <= '0;
            bit_cnt   <= '0;
            rd_sh     <= '0;
            o_sda     <= 1'b0;
            o_sda_dir <= 1'b0;
        end else begin
            if (state == IDLE && sen_fall) bit_cnt <= '0;
            if (take_bit) begin
                shift_q <= {shift_q[13:0], sda_s};
                bit_cnt <= bit_cnt + 5'd1;
            end
            if (rd_load) rd_sh <= rd_value;
            if (rd_shift) begin
                o_sda     <= rd_sh[7];
                o_sda_dir <= 1'b1;
                rd_sh     <= {rd_sh[6:0], 1'b0};
            end
            if (sen_s) begin
                o_sda     <= 1'b0;
                o_sda_dir <= 1'b0;
            end
        end
    end

    // Later assignments override earlier ones, so a write beats counter expiry
    // and the bit5 self-clear.
    always_ff @(posedge clk_in) begin
        if (clear) begin
            for (int unsigned i = 0; i < 128; i++) regs[i] <= '0;
            align_cnt  <= '0;
            o_wr_valid <= 1'b0;
            o_wr_addr  <= '0;
            o_wr_data  <= '0;
        end else begin
            o_wr_valid <= wr_commit;
            if (wr_commit) begin
                o_wr_addr <= wr_addr;
                o_wr_data <= wr_data;
            end
            if (regs[ADDR_SOFT][5]) regs[ADDR_SOFT][5] <= 1'b0;
            if (align_cnt != '0) begin
                align_cnt <= align_cnt - CNT_W'(1);
                if (align_cnt == CNT_W'(1)) regs[ADDR_ALIGN][2] <= 1'b1;
            end
            if (wr_commit) begin
                if (wr_addr == ADDR_SOFT && wr_data[5]) begin
                    for (int unsigned i = 1; i < 128; i++) regs[i] <= '0;
                    regs[ADDR_SOFT] <= wr_data;
                    align_cnt       <= '0;
                end else if (wr_addr == ADDR_ALIGN) begin
                    regs[ADDR_ALIGN] <= wr_data & 8'hFB;
                    align_cnt        <= wr_data[1] ? CNT_W'(ALIGN_DELAY) : '0;
                end else if (wr_addr != ADDR_FIFO) begin
                    regs[wr_addr] <= wr_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_ad9122_spi_slave_model.sv
// Directed bench for ad9122_spi_slave_model: a timestamped register model
// predicts read data and a write scoreboard checks every o_wr_valid pulse.
module tb_ad9122_spi_slave_model;

    localparam int unsigned ALIGN = 300;
    localparam int          HALF  = 8;

    logic       clk_in  = 1'b0;
    logic       rst_n   = 1'b0;
    logic       i_reset = 1'b0;
    logic       i_sclk  = 1'b0;
    logic       i_sen_n = 1'b1;
    logic       i_sda   = 1'b0;
    logic       o_sda, o_sda_dir, o_wr_valid;
    logic [6:0] o_wr_addr;
    logic [7:0] o_wr_data;

    ad9122_spi_slave_model #(
        .SYNC_STAGES(2),
        .ALIGN_DELAY(ALIGN),
        .FIFO_LEVEL (8'h07)
    ) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .i_reset   (i_reset),
        .i_sclk    (i_sclk),
        .i_sen_n   (i_sen_n),
        .i_sda     (i_sda),
        .o_sda     (o_sda),
        .o_sda_dir (o_sda_dir),
        .o_wr_valid(o_wr_valid),
        .o_wr_addr (o_wr_addr),
        .o_wr_data (o_wr_data)
    );

    always #5 clk_in = ~clk_in;

    int unsigned cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Register model: plain array plus a timestamp for the align handshake
    typedef struct { logic [6:0] a; logic [7:0] d; } wr_t;
    wr_t         exp_q[$];
    logic [7:0]  mem [128];
    bit          align_armed = 1'b0;
    int unsigned align_start = 0;

    function automatic void model_clear();
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;
        align_armed = 1'b0;
    endfunction

    function automatic void model_write(input logic [6:0] a, input logic [7:0] d);
        wr_t w;
        w.a = a;
        w.d = d;
        exp_q.push_back(w);
        if (a == 7'h19) return;
        if (a == 7'h00 && d[5]) begin
            for (int i = 1; i < 128; i++) mem[i] = 8'h00;
            mem[0]      = d & 8'hDF;
            align_armed = 1'b0;
        end else if (a == 7'h18) begin
            mem[a]      = d & 8'hFB;
            align_armed = d[1];
            align_start = cyc;
        end else begin
            mem[a] = d;
        end
    endfunction

    function automatic logic [7:0] model_read(input logic [6:0] a);
        logic [7:0] v;
        if (a == 7'h19) return 8'h07;
        v = mem[a];
        if (a == 7'h18 && align_armed && (cyc - align_start) >= ALIGN) v = v | 8'h04;
        return v;
    endfunction

    // Every committed-write pulse must match the next expected write, once
    always @(negedge clk_in) begin
        if (o_wr_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("wr_unexpected", o_wr_valid, 0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", o_wr_addr, e.a);
                check("wr_data", o_wr_data, e.d);
            end
        end
    end

    task automatic spi_xfer(input logic [15:0] frame, input int nbits, input int rst_at,
                            output logic [7:0] rd, output int dir_bad);
        bit hit_reset;
        hit_reset = 1'b0;
        rd        = 8'h00;
        dir_bad   = 0;
        @(negedge clk_in);
        i_sen_n = 1'b0;
        repeat (HALF) @(negedge clk_in);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                i_reset = 1'b1;
                repeat (2) @(negedge clk_in);
                i_reset   = 1'b0;
                hit_reset = 1'b1;
                model_clear();
                check("ireset_dir", o_sda_dir, 0);
                check("ireset_wr_valid", o_wr_valid, 0);
            end
            i_sda = (i < 16) ? frame[15-i] : 1'b0;
            repeat (HALF) @(negedge clk_in);
            if (i >= 8 && i < 16) begin
                rd = {rd[6:0], o_sda};
                if (o_sda_dir !== (frame[15] && !hit_reset)) dir_bad++;
            end else if (i < 8 && o_sda_dir !== 1'b0) begin
                dir_bad++;
            end
            if (i == 15 && !frame[15] && !hit_reset) model_write(frame[14:8], frame[7:0]);
            i_sclk = 1'b1;
            repeat (HALF) @(negedge clk_in);
            i_sclk = 1'b0;
        end
        repeat (HALF) @(negedge clk_in);
        i_sen_n = 1'b1;
        repeat (3 * HALF) @(negedge clk_in);
        if (o_sda_dir !== 1'b0) dir_bad++;
    endtask

    task automatic do_write(input logic [6:0] a, input logic [7:0] d);
        logic [7:0] rd;
        int         bad;
        spi_xfer({1'b0, a, d}, 16, -1, rd, bad);
        check("write_dir_low", bad, 0);
    endtask

    task automatic do_read(input string name, input logic [6:0] a, output logic [7:0] rd);
        logic [7:0] exp;
        int         bad;
        exp = model_read(a);
        spi_xfer({1'b1, a, 8'h00}, 16, -1, rd, bad);
        check({name, "_model"}, rd, exp);
        check({name, "_dir"}, bad, 0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd;
        int         bad;
        model_clear();
        repeat (5) @(negedge clk_in);
        rst_n = 1'b1;
        repeat (10) @(negedge clk_in);
        check("rst_sda", o_sda, 0);
        check("rst_sda_dir", o_sda_dir, 0);
        check("rst_wr_valid", o_wr_valid, 0);
        check("rst_wr_addr", o_wr_addr, 0);
        check("rst_wr_data", o_wr_data, 0);

        do_read("rd1b_reset", 7'h1B, rd);     check("rd1b_reset_lit", rd, 8'h00);
        do_write(7'h1B, 8'hA4);
        do_read("rd1b", 7'h1B, rd);           check("rd1b_lit", rd, 8'hA4);

        do_read("rd19", 7'h19, rd);           check("rd19_lit", rd, 8'h07);
        do_write(7'h19, 8'hFF);
        do_read("rd19_after", 7'h19, rd);     check("rd19_after_lit", rd, 8'h07);

        do_write(7'h18, 8'h02);
        do_read("align_early", 7'h18, rd);    check("align_early_lit", rd, 8'h02);
        repeat (ALIGN + 4) @(negedge clk_in);
        do_read("align_ack", 7'h18, rd);      check("align_ack_lit", rd, 8'h06);
        do_write(7'h18, 8'h02);
        do_read("align_restart", 7'h18, rd); check("align_restart_lit", rd, 8'h02);
        do_write(7'h18, 8'h00);
        repeat (ALIGN + 4) @(negedge clk_in);
        do_read("align_stop", 7'h18, rd);     check("align_stop_lit", rd, 8'h00);

        spi_xfer({1'b0, 7'h40, 8'h5A}, 12, -1, rd, bad);
        check("abort_dir", bad, 0);
        do_read("abort_rd40", 7'h40, rd);     check("abort_rd40_lit", rd, 8'h00);

        do_write(7'h45, 8'h02);
        do_read("rd45", 7'h45, rd);           check("rd45_lit", rd, 8'h02);
        do_write(7'h00, 8'h20);
        do_read("soft_rd45", 7'h45, rd);      check("soft_rd45_lit", rd, 8'h00);
        do_read("soft_rd00", 7'h00, rd);      check("soft_rd00_lit", rd, 8'h00);
        do_read("soft_rd1b", 7'h1B, rd);      check("soft_rd1b_lit", rd, 8'h00);

        spi_xfer({1'b0, 7'h1C, 8'h04}, 20, -1, rd, bad);
        check("extra_edges_dir", bad, 0);
        do_read("rd1c", 7'h1C, rd);           check("rd1c_lit", rd, 8'h04);

        spi_xfer({1'b0, 7'h50, 8'h5A}, 16, 6, rd, bad);
        check("ireset_frame_dir", bad, 0);
        do_read("ireset_rd50", 7'h50, rd);    check("ireset_rd50_lit", rd, 8'h00);
        do_read("ireset_rd1c", 7'h1C, rd);    check("ireset_rd1c_lit", rd, 8'h00);
        do_write(7'h50, 8'h33);
        do_read("post_rd50", 7'h50, rd);      check("post_rd50_lit", rd, 8'h33);

        repeat (20) @(negedge clk_in);
        check("wr_all_seen", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
